gpca_driver: RTL and testbench
==============================

Name: gpca_driver

Overview:
Sequencing front end for the combinational general purpose cellular array (gpca). It accepts one arithmetic request (multiply, square, square root or divide) over a valid/ready handshake. It formats the operands into the array's X/P/A/B/C fields, left-justifying the B operand by iterative shifting, then holds the drive for a programmable settle time. Finally it captures the array's F/S outputs and returns them over a valid/ready response channel. The block sits between the datapath sequencer and one gpca instance and is the only agent that drives the array.

Parameters:
SETTLE_CYCLES, 4, cycles the array inputs are held before F/S are sampled (legal 1..15)

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  request offered
req_ready  out  1  block idle, request accepted when both high
req_op  in  2  0=MUL 1=SQR 2=SQRT 3=DIV
req_a  in  10  dividend / radicand, right-justified; bit 1 = MSB
req_b  in  7  multiplicand / divisor, right-justified; bit 1 = MSB
req_p  in  5  multiplier / square operand
arr_x  out  1  array mode (0 = MUL/SQR, 1 = SQRT/DIV)
arr_p  out  5  array P
arr_a  out  10  array A
arr_b  out  7  array B
arr_c  out  7  array C
arr_f  in  5  array F (quotient/root bits)
arr_s  in  11  array S (product/remainder)
rsp_valid  out  1  result held
rsp_ready  in  1  result consumed when both high
rsp_f  out  5  captured arr_f
rsp_s  out  11  captured arr_s
rsp_shift  out  3  left shifts applied to req_b
rsp_err  out  1  DIV with req_b = 0

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0 except req_ready = 1. State = IDLE.
- States: IDLE, NORM, DRIVE, RESP. All outputs are registered.
- IDLE:
  - req_ready = 1.
  - On accept, latch the operands and clear shift_cnt.
  - If op = DIV and req_b = 0: go to RESP with rsp_err = 1, rsp_f = 0, rsp_s = 0. The array is never driven.
  - Else if op is MUL or DIV and the b MSB = 0: go to NORM.
  - Else: go to DRIVE.
- NORM:
  - Each cycle: b <= b << 1 and shift_cnt++.
  - Go to DRIVE in the cycle the shifted b has MSB = 1. Maximum 6 cycles.
  - MUL with b = 0 skips NORM; shift = 0.
- DRIVE:
  - arr_* are driven from the latched fields. Settle counter loads SETTLE_CYCLES-1 on entry and decrements.
  - At count 0, capture arr_f/arr_s into rsp_f/rsp_s, set rsp_valid = 1 and go to RESP.
- Field formatting:
  - MUL: x=0, p=req_p, a=0, b=c=normalized b.
  - SQR: x=0, p=req_p, a=0, b=7'b0011111, c=7'b0100000.
  - SQRT: x=1, p=0, a=req_a, b=7'b0011111, c=7'b0100000.
  - DIV: x=1, p=0, a=req_a, b=c=normalized b.
- arr_* outputs are 0 in every state except DRIVE.
- RESP:
  - rsp_* are held stable while rsp_ready = 0.
  - On rsp_valid & rsp_ready: clear rsp_valid, rsp_err and rsp_shift, then go to IDLE. req_ready rises in the following cycle; there is no same-cycle turnaround.
- Latency (accept at cycle 0, k = shift count): rsp_valid rises at cycle 1+k+SETTLE_CYCLES. A DIV-by-zero request responds at cycle 1.
- req_valid is ignored outside IDLE. Request fields need only be valid in the accept cycle.
- Reset mid-operation (any state): next cycle all outputs at their reset values, state IDLE, any pending response discarded.
- Undefined req_op does not exist (2-bit encoding is complete).

Decomposition:
- Shared include gpca_defs.vh holds:
  - opcode localparams OP_MUL/OP_SQR/OP_SQRT/OP_DIV;
  - the SQ_B = 7'b0011111 and SQ_C = 7'b0100000 constants;
  - state encodings.
- One natural sub-module: gpca_fmt, a combinational mapping from (op, a, normalized b, p) to (x, p, a, b, c). It is reused by bench models.
- The array itself stays external.

Test Plan:
- MUL, req_b=0000111, req_p=00101, SETTLE=4 -> 4 NORM cycles; DRIVE x=0, p=00101, a=0, b=c=1110000; rsp_valid at cycle 9, rsp_shift=4, rsp_s = the array model's output.
- SQRT, req_a=0000011001 -> no NORM; DRIVE x=1, p=0, a=0000011001, b=0011111, c=0100000; rsp_valid at cycle 5, rsp_shift=0.
- DIV, req_a=1100010000, req_b=0000101 -> shift 4, b=c=1010000, x=1; rsp_f/rsp_s equal the model's values at the DRIVE end.
- DIV, req_b=0 -> rsp_valid at cycle 1 with rsp_err=1, rsp_s=0; arr_* remain 0 throughout.
- Back-pressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* constant, req_ready=0, a second req_valid is ignored; release -> IDLE the next cycle.
- Assert rst during the second NORM cycle of a MUL -> next cycle all outputs 0, req_ready=1; a new SQR then completes normally.

Source files
------------

// File: rtl/gpca_driver_pkg.sv
// Shared opcodes, square/root constants, FSM encoding and the array field
// bundle used by the gpca sequencing front end.
package gpca_driver_pkg;

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_SQR  = 2'd1;
  localparam logic [1:0] OP_SQRT = 2'd2;
  localparam logic [1:0] OP_DIV  = 2'd3;

  // Fixed B/C pattern the array expects for square and square root.
  localparam logic [6:0] SQ_B = 7'b0011111;
  localparam logic [6:0] SQ_C = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic       x;
    logic [4:0] p;
    logic [9:0] a;
    logic [6:0] b;
    logic [6:0] c;
  } arr_fields_t;

  // MUL/DIV need a left-justified B; a zero B cannot be justified and is
  // either driven as-is (MUL) or rejected earlier (DIV).
  function automatic logic needs_norm(input logic [1:0] op, input logic [6:0] b);
    return ((op == OP_MUL) || (op == OP_DIV)) && (b != 7'd0) && !b[6];
  endfunction

endpackage

// File: rtl/gpca_fmt.sv
// Combinational mapping from a request (op, a, normalized b, p) to the
// array's X/P/A/B/C input fields.
module gpca_fmt
  import gpca_driver_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [9:0]  a,
  input  logic [6:0]  b,
  input  logic [4:0]  p,
  output arr_fields_t fld
);

  // Select the field layout for each operation.
  always_comb begin
    fld = '0;
    case (op)
      OP_MUL: begin
        fld.x = 1'b0; fld.p = p; fld.a = '0; fld.b = b; fld.c = b;
      end
      OP_SQR: begin
        fld.x = 1'b0; fld.p = p; fld.a = '0; fld.b = SQ_B; fld.c = SQ_C;
      end
      OP_SQRT: begin
        fld.x = 1'b1; fld.p = '0; fld.a = a; fld.b = SQ_B; fld.c = SQ_C;
      end
      default: begin
        fld.x = 1'b1; fld.p = '0; fld.a = a; fld.b = b; fld.c = b;
      end
    endcase
  end

endmodule

// File: rtl/gpca_driver.sv
// Sequencing front end for one gpca instance: accepts a request, normalizes
// B, drives the array for SETTLE_CYCLES, captures F/S and returns them.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE. rsp_valid stays high and
// rsp_* stay constant until the edge where rsp_ready is also high.
module gpca_driver
  import gpca_driver_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [9:0]  req_a,
  input  logic [6:0]  req_b,
  input  logic [4:0]  req_p,
  output logic        arr_x,
  output logic [4:0]  arr_p,
  output logic [9:0]  arr_a,
  output logic [6:0]  arr_b,
  output logic [6:0]  arr_c,
  input  logic [4:0]  arr_f,
  input  logic [10:0] arr_s,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_f,
  output logic [10:0] rsp_s,
  output logic [2:0]  rsp_shift,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  op_q, op_d;
  logic [9:0]  a_q, a_d;
  logic [6:0]  b_q, b_d;
  logic [4:0]  p_q, p_d;
  logic [2:0]  shift_q;
  logic [3:0]  settle_q;
  arr_fields_t fld_d;
  logic        accept;
  logic        div0;
  logic [6:0]  b_shl;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign div0      = (req_op == OP_DIV) && (req_b == 7'd0);
  assign b_shl     = {b_q[5:0], 1'b0};
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (div0)                          state_nxt = ST_RESP;
          else if (needs_norm(req_op, req_b)) state_nxt = ST_NORM;
          else                               state_nxt = ST_DRIVE;
        end
      end
      ST_NORM:  if (b_shl[6]) state_nxt = ST_DRIVE;
      ST_DRIVE: if (settle_q == 4'd0) state_nxt = ST_RESP;
      default:  if (rsp_ready) state_nxt = ST_IDLE;
    endcase
  end

  // Operand values for next cycle: latch on accept, shift B while normalizing.
  always_comb begin
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    p_d  = p_q;
    if (accept) begin
      op_d = req_op;
      a_d  = req_a;
      b_d  = req_b;
      p_d  = req_p;
    end else if (state == ST_NORM) begin
      b_d = b_shl;
    end
  end

  gpca_fmt u_fmt (
    .op  (op_d),
    .a   (a_d),
    .b   (b_d),
    .p   (p_d),
    .fld (fld_d)
  );

  // Registered datapath and outputs, driven from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      shift_q   <= '0;
      settle_q  <= '0;
      req_ready <= 1'b1;
      arr_x     <= 1'b0;
      arr_p     <= '0;
      arr_a     <= '0;
      arr_b     <= '0;
      arr_c     <= '0;
      rsp_valid <= 1'b0;
      rsp_f     <= '0;
      rsp_s     <= '0;
      rsp_shift <= '0;
      rsp_err   <= 1'b0;
    end else begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
      p_q  <= p_d;

      if (accept)                 shift_q <= '0;
      else if (state == ST_NORM)  shift_q <= shift_q + 3'd1;

      if ((state_nxt == ST_DRIVE) && (state != ST_DRIVE))
        settle_q <= SETTLE_LOAD;
      else if ((state == ST_DRIVE) && (settle_q != 4'd0))
        settle_q <= settle_q - 4'd1;

      req_ready <= (state_nxt == ST_IDLE);

      // The array sees fields only while in DRIVE.
      if (state_nxt == ST_DRIVE) begin
        arr_x <= fld_d.x;
        arr_p <= fld_d.p;
        arr_a <= fld_d.a;
        arr_b <= fld_d.b;
        arr_c <= fld_d.c;
      end else begin
        arr_x <= 1'b0;
        arr_p <= '0;
        arr_a <= '0;
        arr_b <= '0;
        arr_c <= '0;
      end

      if (accept && div0) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_f     <= '0;
        rsp_s     <= '0;
        rsp_shift <= '0;
      end else if ((state == ST_DRIVE) && (settle_q == 4'd0)) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_f     <= arr_f;
        rsp_s     <= arr_s;
        rsp_shift <= shift_q;
      end else if ((state == ST_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_shift <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gpca_driver.sv
// Bench for gpca_driver: directed cases plus randomized requests, with a
// stand-in combinational array and a behavioural model of the sequencing.
module tb_gpca_driver;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [9:0]  req_a = '0;
  logic [6:0]  req_b = '0;
  logic [4:0]  req_p = '0;
  logic        arr_x;
  logic [4:0]  arr_p;
  logic [9:0]  arr_a;
  logic [6:0]  arr_b;
  logic [6:0]  arr_c;
  logic [4:0]  arr_f;
  logic [10:0] arr_s;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [4:0]  rsp_f;
  logic [10:0] rsp_s;
  logic [2:0]  rsp_shift;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];

  gpca_driver #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_p(req_p),
    .arr_x(arr_x), .arr_p(arr_p), .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c),
    .arr_f(arr_f), .arr_s(arr_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_s(rsp_s),
    .rsp_shift(rsp_shift), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Stand-in array: any fixed function of its inputs will do.
  function automatic logic [15:0] arr_fn(input logic x, input logic [4:0] p,
                                         input logic [9:0] a, input logic [6:0] b,
                                         input logic [6:0] c);
    logic [4:0]  f;
    logic [10:0] s;
    if (!x) begin
      s = 11'(int'(p) * int'(b)) ^ {4'b0, c};
      f = p ^ c[4:0];
    end else begin
      f = (b != 7'd0) ? 5'(a / b) : 5'h1f;
      s = (b != 7'd0) ? 11'(a % b) : 11'h7ff;
      s = s ^ {c, 4'b0};
    end
    return {f, s};
  endfunction

  assign {arr_f, arr_s} = arr_fn(arr_x, arr_p, arr_a, arr_b, arr_c);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: field layout, shift count and error from the op rules.
  task automatic model(input logic [1:0] op, input logic [9:0] a, input logic [6:0] b,
                       input logic [4:0] p, output logic [29:0] fld, output int k,
                       output bit err);
    logic [6:0] bn;
    bn  = b;
    k   = 0;
    err = (op == 2'd3) && (b == 7'd0);
    if ((op == 2'd0 || op == 2'd3) && b != 7'd0) begin
      while (bn[6] == 1'b0) begin
        bn = bn << 1;
        k++;
      end
    end
    case (op)
      2'd0:    fld = {1'b0, p, 10'd0, bn, bn};
      2'd1:    fld = {1'b0, p, 10'd0, 7'b0011111, 7'b0100000};
      2'd2:    fld = {1'b1, 5'd0, a, 7'b0011111, 7'b0100000};
      default: fld = {1'b1, 5'd0, a, bn, bn};
    endcase
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp"}, 32'({rsp_valid, rsp_f, rsp_s, rsp_shift, rsp_err}), 32'd0);
    check({tag, "_arr"}, 32'({arr_x, arr_p, arr_a, arr_b, arr_c}), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Driver: issue one request, follow it cycle by cycle, hold the response
  // for `hold` cycles (optionally offering ignored requests), then consume.
  task automatic run_txn(input logic [1:0] op, input logic [9:0] a, input logic [6:0] b,
                         input logic [4:0] p, input int hold, input bit noise);
    logic [29:0] fld;
    logic [29:0] efld;
    logic [19:0] exp_r;
    int k, lat, cyc;
    bit err, seen;
    model(op, a, b, p, fld, k, err);
    lat = err ? 1 : 1 + k + S;
    if (err) exp_q.push_back(20'({5'd0, 11'd0, 3'd0, 1'b1}));
    else     exp_q.push_back({arr_fn(fld[29], fld[28:24], fld[23:14], fld[13:7], fld[6:0]),
                              3'(k), 1'b0});

    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_p = p;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_a = 10'($urandom); req_b = 7'($urandom); req_p = 5'($urandom);

    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      efld = (!err && cyc >= 1 + k && cyc <= k + S) ? fld : 30'd0;
      check("arr_fields", 32'({arr_x, arr_p, arr_a, arr_b, arr_c}), 32'(efld));
      check("req_ready_busy", 32'(req_ready), 32'd0);
      if (rsp_valid) seen = 1'b1;
    end
    check("rsp_latency", 32'(cyc), 32'(lat));

    exp_r = exp_q.pop_front();
    check("rsp_data", 32'({rsp_f, rsp_s, rsp_shift, rsp_err}), 32'(exp_r));

    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        req_valid = 1'b1;
        req_op = 2'($urandom); req_a = 10'($urandom); req_b = 7'($urandom); req_p = 5'($urandom);
      end
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'({rsp_f, rsp_s, rsp_shift, rsp_err}), 32'(exp_r));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;

    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("post_err_shift", 32'({rsp_err, rsp_shift}), 32'd0);
  endtask

  // Main sequence and final report.
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    run_txn(2'd0, 10'd0,          7'b0000111, 5'b00101, 0, 1'b0);
    run_txn(2'd2, 10'b0000011001, 7'd0,       5'd0,     0, 1'b0);
    run_txn(2'd3, 10'b1100010000, 7'b0000101, 5'd0,     2, 1'b0);
    run_txn(2'd3, 10'd123,        7'd0,       5'd0,     0, 1'b0);
    run_txn(2'd0, 10'd0,          7'd0,       5'd9,     0, 1'b0);
    run_txn(2'd1, 10'd77,         7'd55,      5'd17,   10, 1'b1);
    run_txn(2'd3, 10'h3ff,        7'b1000000, 5'd0,     1, 1'b0);
    run_txn(2'd0, 10'd0,          7'd1,       5'd31,    0, 1'b0);

    // Reset during the second NORM cycle of a MUL.
    req_valid = 1'b1; req_op = 2'd0; req_a = 10'd0; req_b = 7'b0000011; req_p = 5'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    rst = 1'b0;
    run_txn(2'd1, 10'd0, 7'd0, 5'd21, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [6:0] rb;
      rb = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom);
      run_txn(2'($urandom_range(0, 3)), 10'($urandom), rb, 5'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog against a stuck handshake.
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
